// File: rtl/hs_rx_responder.sv
// hs_rx_responder: receive side of a 4-phase req/ack CDC handshake.
// Synchronises req_in, captures data_in, hands it over via valid/ready.
module hs_rx_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("hs_rx_responder: SYNC_STAGES must be 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [1:0]             state;

    assign req_s = req_sync[SYNC_STAGES-1];

    // Synchroniser chain; the only logic that ever samples req_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    // Handshake FSM with registered ack/valid/data/count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ack_out    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // data_in has been stable for SYNC_STAGES cycles here
                    if (req_s) begin
                        dout       <= data_in;
                        dout_valid <= 1'b1;
                        state      <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        ack_out    <= 1'b1;
                        xfer_cnt   <= xfer_cnt + CNT_ONE;
                        state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // wait for the sender to close the 4-phase cycle
                    if (!req_s) begin
                        ack_out <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    ack_out    <= 1'b0;
                    dout_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag: sender withdrew req before the word was acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (state == ST_VALID && !req_s) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_rx_responder.sv
// tb_hs_rx_responder: randomized transaction-level bench.
// Expected values come from handshake timing rules and a transfer count.
module tb_hs_rx_responder;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] xfer_cnt;
    logic          proto_err;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    bit err_flag = 1'b0;

    hs_rx_responder #(
        .DATA_W     (DW),
        .SYNC_STAGES(SS),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against the model; dout only while valid.
    task automatic expect_st(input string tag, input bit ack, input bit vld,
                             input logic [DW-1:0] d);
        chk({tag, ".ack"}, 32'(ack_out), 32'(ack));
        chk({tag, ".vld"}, 32'(dout_valid), 32'(vld));
        chk({tag, ".cnt"}, 32'(xfer_cnt), 32'(n_xfer % (1 << CW)));
        chk({tag, ".perr"}, 32'(proto_err), 32'(err_flag));
        if (vld) chk({tag, ".dout"}, 32'(dout), 32'(d));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        n_xfer = 0;
        err_flag = 1'b0;
        expect_st("rst", 1'b0, 1'b0, '0);
        chk("rst.dout", 32'(dout), 32'd0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    // One well-behaved 4-phase transfer.
    task automatic xfer(input logic [DW-1:0] d, input int stall,
                        input int hold);
        data_in = d;
        req_in = 1'b1;
        dout_ready = (stall == 0);
        for (int e = 1; e <= SS; e++) begin
            tick;
            expect_st("sync", 1'b0, 1'b0, d);
        end
        tick;
        expect_st("cap", 1'b0, 1'b1, d);
        data_in = ~d;
        for (int i = 0; i < stall; i++) begin
            tick;
            expect_st("stall", 1'b0, 1'b1, d);
        end
        dout_ready = 1'b1;
        tick;
        n_xfer++;
        expect_st("acc", 1'b1, 1'b0, d);
        dout_ready = 1'($urandom);
        for (int i = 0; i < hold; i++) begin
            tick;
            expect_st("hold", 1'b1, 1'b0, d);
        end
        req_in = 1'b0;
        for (int e = 1; e <= SS; e++) begin
            tick;
            expect_st("close", 1'b1, 1'b0, d);
        end
        tick;
        expect_st("ackdn", 1'b0, 1'b0, d);
    endtask

    // Sender drops req while the word is still waiting for ready.
    task automatic proto_case(input logic [DW-1:0] d);
        data_in = d;
        req_in = 1'b1;
        dout_ready = 1'b0;
        for (int e = 1; e <= SS + 1; e++) tick;
        expect_st("pe.cap", 1'b0, 1'b1, d);
        req_in = 1'b0;
        for (int e = 1; e <= SS; e++) begin
            tick;
            expect_st("pe.pre", 1'b0, 1'b1, d);
        end
        tick;
        err_flag = 1'b1;
        expect_st("pe.set", 1'b0, 1'b1, d);
        tick;
        expect_st("pe.wait", 1'b0, 1'b1, d);
        dout_ready = 1'b1;
        tick;
        n_xfer++;
        expect_st("pe.acc", 1'b1, 1'b0, d);
        tick;
        expect_st("pe.idle", 1'b0, 1'b0, d);
    endtask

    // Reset while in ACK with req still high; request is recaptured.
    task automatic reset_mid(input logic [DW-1:0] d);
        data_in = d;
        req_in = 1'b1;
        dout_ready = 1'b1;
        for (int e = 1; e <= SS + 2; e++) tick;
        n_xfer++;
        expect_st("rm.ack", 1'b1, 1'b0, d);
        #2;
        do_reset;
        for (int e = 1; e <= SS; e++) begin
            tick;
            expect_st("rm.sync", 1'b0, 1'b0, d);
        end
        tick;
        expect_st("rm.cap", 1'b0, 1'b1, d);
        tick;
        n_xfer++;
        expect_st("rm.acc", 1'b1, 1'b0, d);
        req_in = 1'b0;
        for (int e = 1; e <= SS + 1; e++) tick;
        expect_st("rm.dn", 1'b0, 1'b0, d);
    endtask

    initial begin
        rst = 1'b1;
        req_in = 1'b0;
        data_in = '0;
        dout_ready = 1'b0;
        #12;
        do_reset;
        tick;
        expect_st("idle", 1'b0, 1'b0, '0);

        xfer(8'hA5, 0, 2);
        xfer(8'h3C, 10, 1);
        xfer(8'h5A, 0, 3);
        proto_case(8'h77);
        xfer(8'hC3, 1, 0);

        do_reset;
        for (int k = 0; k < 17; k++) begin
            xfer(DW'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        reset_mid(8'h96);
        xfer(DW'($urandom), int'($urandom_range(0, 4)), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
